i2c_init_sequencer: RTL and testbench
=====================================

Name: i2c_init_sequencer

Overview:
Parametrised ROM-driven I2C initialisation sequencer; successor to the fixed single-sequence ROM walker.
- Fetches command words from an external synchronous ROM (1-cycle read latency).
- Hands WRITE payloads to the i2c master with a send/done/ready handshake.
- Supports timed DELAY commands and in-ROM END markers, so several sequences can share one ROM.
- Retries NACKed transfers and reports completion or error.

Parameters:
- ROM_DEPTH, 128, ROM entries; address width AW = $clog2(ROM_DEPTH).
- PAYLOAD_W, 16, payload bits passed to the i2c master; entry width EW = PAYLOAD_W+2.
- DELAY_UNIT, 1000, clk cycles per DELAY count.
- MAX_RETRY, 3, extra attempts per WRITE after a NACK (0 = no retry).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- seq_base_i  in  AW  ROM address of the first command; latched on start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  1-cycle pulse on END reached
- err_o  out  1  sticky error flag; cleared on next accepted start or reset
- cmd_cnt_o  out  AW  commands executed in current/last run (WRITE and DELAY; END excluded)
- rom_addr_o  out  AW  ROM address
- rom_data_i  in  EW  ROM data; valid the cycle after rom_addr_o is presented
- i2c_send_o  out  1  request to i2c master
- i2c_data_o  out  PAYLOAD_W  payload to i2c master
- i2c_done_i  in  1  1-cycle transfer-complete pulse
- i2c_nack_i  in  1  qualifies i2c_done_i: transfer was NACKed
- i2c_ready_i  in  1  i2c master idle

Behaviour:
- Entry decode: op = rom_data_i[EW-1:EW-2]; 00 WRITE, 01 DELAY, 10 END, 11 illegal; payload = low PAYLOAD_W bits.
- Reset values: all outputs 0; state IDLE; ptr 0; retry counter 0.
- IDLE: on start_i -> ptr <= seq_base_i, cmd_cnt_o <= 0, err_o <= 0, go to FETCH. start_i in any other state is ignored.
- FETCH: rom_addr_o = ptr; next cycle go to DECODE. rom_addr_o holds ptr in all states.
- DECODE: register the entry.
  - WRITE -> WAIT_RDY with i2c_data_o <= payload and retry counter <= 0.
  - DELAY -> DELAY with the counter loaded to payload*DELAY_UNIT. Compute in PAYLOAD_W+$clog2(DELAY_UNIT)+1 bits; no truncation.
  - END -> FINISH.
  - illegal -> ERROR.
- WAIT_RDY: wait for i2c_ready_i = 1, then go to SEND.
- SEND: i2c_send_o = 1 for exactly one cycle, then go to WAIT_DONE. i2c_data_o is stable from WAIT_RDY through WAIT_DONE.
- WAIT_DONE on i2c_done_i:
  - nack = 0: cmd_cnt_o++, advance ptr, go to FETCH.
  - nack = 1 and retry < MAX_RETRY: retry++, go to WAIT_RDY (same payload).
  - Otherwise go to ERROR.
- DELAY: decrement each cycle; at 0 do cmd_cnt_o++, advance ptr, go to FETCH. Count 0 gives a zero-length delay: one cycle in DELAY.
- Pointer advance: ptr = ptr+1. At ptr = ROM_DEPTH-1 the advance goes to ERROR instead of wrapping; an END is mandatory before the end of the ROM.
- FINISH: done_o = 1 for one cycle, then IDLE.
- ERROR: err_o <= 1, then IDLE next cycle. done_o is not pulsed.
- Command latency: FETCH→DECODE→WAIT_RDY→SEND is at least 3 cycles from address issue to i2c_send_o.
- Reset mid-operation: return to IDLE immediately and clear all outputs. No partial i2c_send_o is held.

Optional Feature:
Macro I2C_SEQ_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYC (default 100000). A counter runs in WAIT_RDY and WAIT_DONE and clears on state entry. When it reaches TIMEOUT_CYC, go to ERROR and set err_o. An extra output port, timeout_o (1 bit, sticky, cleared like err_o), is set on timeout.
- Not defined: no counter and no timeout_o port. WAIT_RDY and WAIT_DONE wait indefinitely.

Test Plan:
- Basic run: ROM[4]=WRITE 0x1234, ROM[5]=WRITE 0xABCD, ROM[6]=END; seq_base_i=4; ack model (done 10 cycles after send, nack=0) -> exactly 2 send pulses with data 0x1234 then 0xABCD, one done_o pulse, cmd_cnt_o=2, err_o=0, busy_o low after.
- Delay: DELAY_UNIT=10; ROM = WRITE 0x0001, DELAY 5, WRITE 0x0002, END -> second i2c_send_o occurs at least 50 cycles after first i2c_done_i; cmd_cnt_o=3.
- Retry: MAX_RETRY=2; first WRITE NACKed twice then acked -> 3 send pulses with identical data, run completes, err_o=0. NACKed 3 times -> 3 sends, err_o=1, no done_o, cmd_cnt_o=0.
- Bad entries: ROM with op=11 at seq_base -> ERROR, err_o=1, no i2c_send_o. No END before ROM_DEPTH-1 -> err_o=1, no wrap to address 0.
- Handshake and start gating: i2c_ready_i held low for 20 cycles -> i2c_send_o held off until ready. start_i pulsed while busy -> ignored, seq_base_i not relatched. rst_i asserted during WAIT_DONE -> all outputs 0 next cycle, state IDLE.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYC=50: i2c_done_i never asserted -> timeout_o=1 and err_o=1 about 50 cycles after send, busy_o=0.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
// ROM-driven I2C initialisation sequencer: walks WRITE/DELAY/END command words from a
// synchronous ROM, retries NACKed writes. Optional watchdog via macro I2C_SEQ_TIMEOUT_EN.
module i2c_init_sequencer #(
    parameter int ROM_DEPTH   = 128,
    parameter int PAYLOAD_W   = 16,
    parameter int DELAY_UNIT  = 1000,
    parameter int MAX_RETRY   = 3,
`ifdef I2C_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 100000,
`endif
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int EW = PAYLOAD_W + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        seq_base_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
`ifdef I2C_SEQ_TIMEOUT_EN
    output logic                 timeout_o,
`endif
    output logic [AW-1:0]        cmd_cnt_o,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [EW-1:0]        rom_data_i,
    output logic                 i2c_send_o,
    output logic [PAYLOAD_W-1:0] i2c_data_o,
    input  logic                 i2c_done_i,
    input  logic                 i2c_nack_i,
    input  logic                 i2c_ready_i
);

    localparam int DW = PAYLOAD_W + $clog2(DELAY_UNIT) + 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_FINISH,
        ST_ERROR
    } state_t;

    state_t               state_q;
    logic [AW-1:0]        ptr_q;
    logic [AW-1:0]        cmd_cnt_q;
    logic                 err_q;
    logic [PAYLOAD_W-1:0] data_q;
    logic [RW-1:0]        retry_q;
    logic [DW-1:0]        delay_q;
    logic                 advance;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_cnt_q;
    logic           timeout_q;
    logic           wait_exit;

    assign wait_exit = (state_q == ST_WAIT_RDY  && i2c_ready_i) ||
                       (state_q == ST_WAIT_DONE && i2c_done_i);
    assign timeout_o = timeout_q;
`endif

    // A command completes either on an ACKed transfer or when its delay has run out.
    assign advance = (state_q == ST_WAIT_DONE && i2c_done_i && !i2c_nack_i) ||
                     (state_q == ST_DELAY && delay_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cmd_cnt_q <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            retry_q   <= '0;
            delay_q   <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ptr_q     <= seq_base_i;
                        cmd_cnt_q <= '0;
                        err_q     <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    case (rom_data_i[EW-1 -: 2])
                        OP_WRITE: begin
                            data_q  <= rom_data_i[PAYLOAD_W-1:0];
                            retry_q <= '0;
                            state_q <= ST_WAIT_RDY;
                        end
                        OP_DELAY: begin
                            delay_q <= DW'(rom_data_i[PAYLOAD_W-1:0]) * DW'(DELAY_UNIT);
                            state_q <= ST_DELAY;
                        end
                        OP_END:  state_q <= ST_FINISH;
                        default: state_q <= ST_ERROR;
                    endcase
                end
                ST_WAIT_RDY: begin
                    if (i2c_ready_i) state_q <= ST_SEND;
                end
                ST_SEND: state_q <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (i2c_done_i && i2c_nack_i) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= ST_WAIT_RDY;
                        end else begin
                            state_q <= ST_ERROR;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_q != '0) delay_q <= delay_q - 1'b1;
                end
                ST_FINISH: state_q <= ST_IDLE;
                ST_ERROR: begin
                    err_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Running off the last ROM entry is a malformed sequence, never a wrap.
            if (advance) begin
                cmd_cnt_q <= cmd_cnt_q + 1'b1;
                if (ptr_q == AW'(ROM_DEPTH - 1)) begin
                    state_q <= ST_ERROR;
                end else begin
                    ptr_q   <= ptr_q + 1'b1;
                    state_q <= ST_FETCH;
                end
            end

`ifdef I2C_SEQ_TIMEOUT_EN
            if (state_q == ST_WAIT_RDY || state_q == ST_WAIT_DONE) begin
                if (wait_exit) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q == TOW'(TIMEOUT_CYC)) begin
                    to_cnt_q  <= '0;
                    timeout_q <= 1'b1;
                    state_q   <= ST_ERROR;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_FINISH);
    assign i2c_send_o = (state_q == ST_SEND);
    assign err_o      = err_q;
    assign cmd_cnt_o  = cmd_cnt_q;
    assign rom_addr_o = ptr_q;
    assign i2c_data_o = data_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: a ROM-walk model predicts sends, counts and flags;
// an I2C slave responder supplies scripted ACK/NACK.
module tb_i2c_init_sequencer;

    localparam int DEPTH = 16;
    localparam int MAXR  = 2;
    localparam int UNIT  = 10;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [3:0]  seq_base;
    logic        busy, done, err, send;
    logic [3:0]  cmd_cnt, rom_addr;
    logic [17:0] rom_q;
    logic [15:0] i2c_data;
    logic        i2c_done, i2c_nack, i2c_ready;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clk = ~clk;

    i2c_init_sequencer #(
        .ROM_DEPTH  (DEPTH),
        .PAYLOAD_W  (16),
        .DELAY_UNIT (UNIT),
`ifdef I2C_SEQ_TIMEOUT_EN
        .TIMEOUT_CYC(50),
`endif
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .seq_base_i (seq_base),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
`ifdef I2C_SEQ_TIMEOUT_EN
        .timeout_o  (timeout),
`endif
        .cmd_cnt_o  (cmd_cnt),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_q),
        .i2c_send_o (send),
        .i2c_data_o (i2c_data),
        .i2c_done_i (i2c_done),
        .i2c_nack_i (i2c_nack),
        .i2c_ready_i(i2c_ready)
    );

    logic [17:0] rom_mem [DEPTH];
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    int          passed = 0, total = 0, cyc = 0;
    logic [15:0] exp_sends[$], got_sends[$];
    int          send_cyc[$], done_cyc[$], nack_plan[$];
    bit          nack_bits[$];
    int          exp_cnt, done_seen;
    bit          exp_err, exp_done, mute = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Walks the ROM image the way the sequence is defined, with no notion of FSM states.
    task automatic model_run(input int base);
        int p = base;
        int wi = 0;
        int k, att;
        exp_sends.delete();
        nack_bits.delete();
        exp_cnt = 0; exp_err = 0; exp_done = 0;
        foreach (nack_plan[i]) begin
            for (int j = 0; j < nack_plan[i]; j++) nack_bits.push_back(1'b1);
            nack_bits.push_back(1'b0);
        end
        forever begin
            logic [17:0] e;
            e = rom_mem[p];
            if (e[17:16] == 2'b10) begin exp_done = 1; break; end
            if (e[17:16] == 2'b11) begin exp_err = 1; break; end
            if (e[17:16] == 2'b00) begin
                k = (wi < nack_plan.size()) ? nack_plan[wi] : 0;
                wi++;
                att = (k > MAXR) ? MAXR + 1 : k + 1;
                for (int j = 0; j < att; j++) exp_sends.push_back(e[15:0]);
                if (k > MAXR) begin exp_err = 1; break; end
            end
            exp_cnt++;
            if (p == DEPTH - 1) begin exp_err = 1; break; end
            p++;
        end
    endtask

    task automatic prep(input int base);
        model_run(base);
        got_sends.delete(); send_cyc.delete(); done_cyc.delete();
        done_seen = 0;
    endtask

    task automatic pulse_start(input int base);
        @(posedge clk); #1;
        start_i = 1'b1; seq_base = 4'(base);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        while (busy && n < limit) begin @(posedge clk); #1; n++; end
        if (busy) chk({nm, "_hang"}, 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_sends(input string nm, input int cnt);
        int n = 0;
        while (got_sends.size() < cnt && n < 2000) begin @(posedge clk); #1; n++; end
        if (got_sends.size() < cnt) chk({nm, "_nosend"}, got_sends.size(), cnt);
    endtask

    task automatic final_checks(input string nm);
        chk({nm, "_sends"}, got_sends.size(), exp_sends.size());
        chk({nm, "_done"}, done_seen, {31'b0, exp_done});
        chk({nm, "_cnt"}, {28'b0, cmd_cnt}, exp_cnt);
        chk({nm, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
        $display("case %s: sends=%0d done=%0d cnt=%0d err=%0b", nm, got_sends.size(), done_seen, cmd_cnt, err);
    endtask

    // Output monitor, sampled on the falling edge.
    initial begin
        bit prev_send = 0, prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (send) begin
                    chk("send_single", {31'b0, prev_send}, 32'd0);
                    if (got_sends.size() < exp_sends.size())
                        chk("send_data", {16'b0, i2c_data}, {16'b0, exp_sends[got_sends.size()]});
                    else
                        chk("send_extra", got_sends.size() + 1, exp_sends.size());
                    got_sends.push_back(i2c_data);
                    send_cyc.push_back(cyc);
                end
                if (done) begin
                    chk("done_single", {31'b0, prev_done}, 32'd0);
                    done_seen++;
                end
            end
            prev_send = send;
            prev_done = done;
        end
    end

    // I2C master stand-in: completes each transfer 10 cycles after the send pulse.
    initial begin
        bit          nb;
        logic [15:0] d;
        i2c_done = 1'b0; i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (send && !mute && !rst_i) begin
                nb = (nack_bits.size() > 0) ? nack_bits.pop_front() : 1'b0;
                d  = i2c_data;
                repeat (9) @(negedge clk);
                if (busy) chk("data_stable", {16'b0, i2c_data}, {16'b0, d});
                i2c_done = 1'b1; i2c_nack = nb;
                done_cyc.push_back(cyc);
                @(negedge clk);
                i2c_done = 1'b0; i2c_nack = 1'b0;
            end
        end
    end

    initial begin
        int ready_cyc;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 18'h2_0000;
        rom_mem[0]  = 18'h3_0000;
        rom_mem[4]  = 18'h0_1234; rom_mem[5]  = 18'h0_ABCD; rom_mem[6]  = 18'h2_0000;
        rom_mem[8]  = 18'h0_0001; rom_mem[9]  = 18'h1_0005; rom_mem[10] = 18'h0_0002;
        rom_mem[11] = 18'h2_0000;
        rom_mem[12] = 18'h0_0C00; rom_mem[13] = 18'h0_0C01; rom_mem[14] = 18'h0_0C02;
        rom_mem[15] = 18'h0_0C03;
        rst_i = 1'b1; start_i = 1'b0; seq_base = 4'd0; i2c_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr", {28'b0, rom_addr}, 32'd0);
        chk("rst_data", {16'b0, i2c_data}, 32'd0);
        rst_i = 1'b0;

        // Basic two-write run
        nack_plan.delete();
        prep(4); pulse_start(4); wait_idle("basic", 3000); final_checks("basic");
        chk("basic_d0", {16'b0, (got_sends.size() > 0) ? got_sends[0] : 16'hxxxx}, 32'h1234);
        chk("basic_d1", {16'b0, (got_sends.size() > 1) ? got_sends[1] : 16'hxxxx}, 32'hABCD);
        chk("basic_cnt_lit", {28'b0, cmd_cnt}, 32'd2);

        // WRITE, DELAY 5, WRITE, END
        prep(8); pulse_start(8); wait_idle("delay", 3000); final_checks("delay");
        chk("delay_cnt_lit", {28'b0, cmd_cnt}, 32'd3);
        if (send_cyc.size() > 1 && done_cyc.size() > 0)
            chk("delay_gap", {31'b0, (send_cyc[1] - done_cyc[0]) >= 5 * UNIT}, 32'd1);
        else
            chk("delay_gap_missing", send_cyc.size(), 32'd2);

        // Two NACKs then ACK on the first write
        nack_plan = '{2};
        prep(4); pulse_start(4); wait_idle("retry_ok", 3000); final_checks("retry_ok");
        chk("retry_ok_sends_lit", got_sends.size(), 32'd4);

        // NACK on every attempt exhausts retries
        nack_plan = '{3};
        prep(4); pulse_start(4); wait_idle("retry_fail", 3000); final_checks("retry_fail");
        chk("retry_fail_sends_lit", got_sends.size(), 32'd3);
        chk("retry_fail_err_lit", {31'b0, err}, 32'd1);
        nack_plan.delete();

        // Illegal opcode at the base address
        prep(0); pulse_start(0); wait_idle("illegal", 3000); final_checks("illegal");
        chk("illegal_err_lit", {31'b0, err}, 32'd1);

        // No END before the last ROM entry
        prep(12); pulse_start(12); wait_idle("noend", 3000); final_checks("noend");
        chk("noend_addr", {28'b0, rom_addr}, 32'd15);

        // Master not ready for 20 cycles
        prep(4);
        i2c_ready = 1'b0;
        pulse_start(4);
        repeat (20) @(posedge clk);
        #1;
        chk("ready_hold", got_sends.size(), 32'd0);
        i2c_ready = 1'b1; ready_cyc = cyc;
        wait_idle("ready", 3000); final_checks("ready");
        if (send_cyc.size() > 0) chk("ready_gate", {31'b0, send_cyc[0] >= ready_cyc}, 32'd1);

        // Start while busy must be ignored (base 0 would error)
        prep(4); pulse_start(4);
        wait_sends("ignore", 1);
        start_i = 1'b1; seq_base = 4'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle("ignore", 3000); final_checks("ignore");

        // Reset during WAIT_DONE of the second write
        prep(4); pulse_start(4);
        wait_sends("rstmid", 2);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_send", {31'b0, send}, 32'd0);
        chk("rstmid_cnt", {28'b0, cmd_cnt}, 32'd0);
        chk("rstmid_addr", {28'b0, rom_addr}, 32'd0);
        chk("rstmid_data", {16'b0, i2c_data}, 32'd0);
        $display("case rstmid: busy=%0b addr=%0d data=0x%0h", busy, rom_addr, i2c_data);
        rst_i = 1'b0;
        repeat (15) @(posedge clk);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Master never completes the transfer
        mute = 1'b1;
        prep(4); pulse_start(4);
        wait_sends("tmo", 1);
        wait_idle("tmo", 3000);
        chk("tmo_flag", {31'b0, timeout}, 32'd1);
        chk("tmo_err", {31'b0, err}, 32'd1);
        chk("tmo_busy", {31'b0, busy}, 32'd0);
        if (send_cyc.size() > 0)
            chk("tmo_window", {31'b0, (cyc - send_cyc[0]) >= 48 && (cyc - send_cyc[0]) <= 64}, 32'd1);
        $display("case tmo: timeout=%0b err=%0b", timeout, err);
        mute = 1'b0;
`endif

        // A fresh start clears the sticky error
        prep(4); pulse_start(4); wait_idle("rerun", 3000); final_checks("rerun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
